// File: rtl/cpu_ocimem_access_arbiter_if.sv
// CPU debug-monitor port and OCI RAM port bundled for the OCI memory arbiter.
// The arbiter uses the slave modport; the CPU/RAM environment uses master.
interface cpu_ocimem_access_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              cpu_req;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_ack;
    logic [31:0]       cpu_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  cpu_req, cpu_write, cpu_addr, cpu_wdata, ram_rdata,
        output cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output cpu_req, cpu_write, cpu_addr, cpu_wdata, ram_rdata,
        input  cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/cpu_ocimem_access_arbiter.sv
// Shares the single-port OCI debug RAM between JTAG strobes and the CPU monitor
// port through an IDLE -> ACCESS -> COMPLETE sequence with round-robin ties.
module cpu_ocimem_access_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_no_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    cpu_ocimem_access_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;
    typedef enum logic {GNT_CPU, GNT_JTAG} grant_t;

    state_t            r_state;
    state_t            w_state_nxt;
    grant_t            r_gnt;
    grant_t            w_gnt;
    logic              r_jtag_pend;
    logic              r_jtag_we;
    logic [31:0]       r_jtag_wdata;
    logic [ADDR_W-1:0] r_jtag_addr;
    logic              r_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [31:0]       r_ram_wdata;
    logic [31:0]       r_mondreg;
    logic              r_ready;
    logic              r_error;
    logic              w_strobe;
    logic              w_accept;
    logic              w_overrun;
    logic              w_jtag_done;
    logic              w_unused_jdo;

    assign w_strobe     = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    // pend stays set through COMPLETE, so it also covers a JTAG access in flight
    assign w_overrun    = w_strobe & r_jtag_pend;
    assign w_accept     = w_strobe & ~r_jtag_pend;
    assign w_jtag_done  = (r_state == COMPLETE) && (r_gnt == GNT_JTAG);
    assign w_unused_jdo = ^{jdo[37:35], jdo[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_jtag_pend  <= 1'b0;
            r_jtag_we    <= 1'b0;
            r_jtag_wdata <= '0;
            r_jtag_addr  <= '0;
            r_mondreg    <= '0;
            r_ready      <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_jtag_pend <= 1'b1;
                r_jtag_we   <= take_action_ocimem_b;
                r_ready     <= 1'b0;
                if (take_action_ocimem_b) r_jtag_wdata <= jdo[34:3];
                if (take_action_ocimem_a) r_jtag_addr  <= jdo[ADDR_W+1:2];
            end else if (w_jtag_done) begin
                r_jtag_pend <= 1'b0;
                r_ready     <= 1'b1;
                r_jtag_addr <= r_jtag_addr + ADDR_W'(1);
                if (!r_we) r_mondreg <= bus.ram_rdata;
            end
            // an overrunning address-load strobe still leaves the error flagged
            if (w_overrun)                 r_error <= 1'b1;
            else if (take_action_ocimem_a) r_error <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt         = r_gnt;
        bus.ram_we    = 1'b0;
        bus.cpu_ack   = 1'b0;
        bus.cpu_rdata = '0;
        case (r_state)
            IDLE: begin
                if (r_jtag_pend || bus.cpu_req) begin
                    w_state_nxt = ACCESS;
                    if (r_jtag_pend && (!bus.cpu_req || r_gnt == GNT_CPU)) w_gnt = GNT_JTAG;
                    else                                                     w_gnt = GNT_CPU;
                end
            end
            ACCESS: begin
                w_state_nxt = COMPLETE;
                bus.ram_we  = r_we;
            end
            COMPLETE: begin
                w_state_nxt = IDLE;
                if (r_gnt == GNT_CPU) begin
                    bus.cpu_ack = 1'b1;
                    if (!r_we) bus.cpu_rdata = bus.ram_rdata;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // r_gnt doubles as the last-granted requester for tie-breaking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_gnt       <= GNT_CPU;
            r_we        <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_state_nxt == ACCESS) begin
                r_gnt <= w_gnt;
                if (w_gnt == GNT_JTAG) begin
                    r_we        <= r_jtag_we;
                    r_ram_addr  <= r_jtag_addr;
                    r_ram_wdata <= r_jtag_wdata;
                end else begin
                    r_we        <= bus.cpu_write;
                    r_ram_addr  <= bus.cpu_addr;
                    r_ram_wdata <= bus.cpu_wdata;
                end
            end
        end
    end

    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;
    assign MonDReg       = r_mondreg;
    assign monitor_ready = r_ready;
    assign monitor_error = r_error;
endmodule

// File: tb/tb_cpu_ocimem_access_arbiter.sv
// Directed bench for the OCI memory arbiter with a behavioural synchronous-read RAM.
module tb_cpu_ocimem_access_arbiter;
    localparam int K_A  = 0;
    localparam int K_NA = 1;
    localparam int K_B  = 2;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_a;
    logic        take_na;
    logic        take_b;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    int          errors;
    int          checks;
    logic [31:0] mem [0:255];

    cpu_ocimem_access_arbiter_if #(.ADDR_W(8)) bus ();

    cpu_ocimem_access_arbiter #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_no_action_ocimem_a (take_na),
        .take_action_ocimem_b    (take_b),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .bus                     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: write and registered read on the rising edge
    initial begin : ram_model
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        mem[8'h00] <= 32'h00C0FFEE;
        mem[8'h30] <= 32'h0BADF00D;
        mem[8'h42] <= 32'h12345678;
        mem[8'hFF] <= 32'hA5A50FF0;
        bus.ram_rdata <= 32'h0;
        forever begin
            @(posedge clk);
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [37:0] jaddr(input logic [7:0] a);
        return {28'h0, a, 2'b00};
    endfunction

    function automatic logic [37:0] jdata(input logic [31:0] d);
        return {3'b000, d, 3'b000};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Pulses one strobe in the current cycle t; returns at cycle t+1
    task automatic jtag_strobe(input int kind, input logic [37:0] payload);
        jdo = payload;
        take_a  = (kind == K_A);
        take_na = (kind == K_NA);
        take_b  = (kind == K_B);
        step();
        take_a = 1'b0; take_na = 1'b0; take_b = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
        checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", monitor_ready); end
        checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL rst_error got=%b exp=0", monitor_error); end
        checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL rst_mondreg got=%h exp=0", MonDReg); end
        checks++; if ({bus.cpu_ack, bus.cpu_rdata} !== 33'h0) begin errors++; $display("FAIL rst_cpu got ack=%b rdata=%h exp 0/0", bus.cpu_ack, bus.cpu_rdata); end
        checks++; if ({bus.ram_we, bus.ram_addr, bus.ram_wdata} !== 41'h0) begin errors++; $display("FAIL rst_ram got we=%b addr=%h wdata=%h exp 0", bus.ram_we, bus.ram_addr, bus.ram_wdata); end

        jtag_strobe(K_A, jaddr(8'h30));
        step();
        checks++; if (bus.ram_addr !== 8'h30 || bus.ram_we !== 1'b0) begin errors++; $display("FAIL rd30_access got addr=%h we=%b exp 30/0", bus.ram_addr, bus.ram_we); end
        repeat (2) step();
        checks++; if (monitor_ready !== 1'b1 || MonDReg !== 32'h0BADF00D) begin errors++; $display("FAIL rd30_data got rdy=%b data=%h exp 1/0badf00d", monitor_ready, MonDReg); end

        jtag_strobe(K_B, jdata(32'hCAFEF00D));
        step();
        checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 8'h31) begin errors++; $display("FAIL wr31_access got we=%b addr=%h exp 1/31", bus.ram_we, bus.ram_addr); end
        reset_n = 1'b0;
        step();
        checks++; if (MonDReg !== 32'h0 || monitor_ready !== 1'b0) begin errors++; $display("FAIL midrst_mon got data=%h rdy=%b exp 0/0", MonDReg, monitor_ready); end
        checks++; if ({bus.ram_we, bus.ram_addr, bus.ram_wdata} !== 41'h0) begin errors++; $display("FAIL midrst_ram got we=%b addr=%h wdata=%h exp 0", bus.ram_we, bus.ram_addr, bus.ram_wdata); end
        reset_n = 1'b1;
        step();
        checks++; if (mem[8'h31] !== 32'h0) begin errors++; $display("FAIL midrst_nowrite got mem31=%h exp 0", mem[8'h31]); end

        jtag_strobe(K_NA, 38'h0);
        repeat (3) step();
        checks++; if (MonDReg !== 32'h00C0FFEE) begin errors++; $display("FAIL rst_addr0 got=%h exp=00c0ffee", MonDReg); end
    endtask

    task automatic test_jtag_write_read();
        jtag_strobe(K_A, jaddr(8'h10));
        repeat (3) step();
        checks++; if (monitor_ready !== 1'b1 || MonDReg !== 32'h0) begin errors++; $display("FAIL rd10 got rdy=%b data=%h exp 1/0", monitor_ready, MonDReg); end

        jtag_strobe(K_B, jdata(32'hDEADBEEF));
        step();
        checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 8'h11 || bus.ram_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr11_access got we=%b addr=%h wdata=%h exp 1/11/deadbeef", bus.ram_we, bus.ram_addr, bus.ram_wdata); end
        step();
        checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL wr11_busy got rdy=%b exp 0", monitor_ready); end
        step();
        checks++; if (monitor_ready !== 1'b1 || MonDReg !== 32'h0) begin errors++; $display("FAIL wr11_done got rdy=%b data=%h exp 1/0", monitor_ready, MonDReg); end
        checks++; if (mem[8'h11] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr11_mem got=%h exp=deadbeef", mem[8'h11]); end

        jtag_strobe(K_A, jaddr(8'h11));
        repeat (2) step();
        checks++; if (MonDReg !== 32'h0 || monitor_ready !== 1'b0) begin errors++; $display("FAIL rd11_t3 got data=%h rdy=%b exp 0/0", MonDReg, monitor_ready); end
        step();
        checks++; if (MonDReg !== 32'hDEADBEEF || monitor_ready !== 1'b1) begin errors++; $display("FAIL rd11_t4 got data=%h rdy=%b exp deadbeef/1", MonDReg, monitor_ready); end
    endtask

    task automatic test_wrap();
        jtag_strobe(K_A, jaddr(8'hFF));
        step();
        checks++; if (bus.ram_addr !== 8'hFF) begin errors++; $display("FAIL wrap_ff_addr got=%h exp=ff", bus.ram_addr); end
        repeat (2) step();
        checks++; if (MonDReg !== 32'hA5A50FF0) begin errors++; $display("FAIL wrap_ff_data got=%h exp=a5a50ff0", MonDReg); end
        jtag_strobe(K_NA, 38'h0);
        step();
        checks++; if (bus.ram_addr !== 8'h00) begin errors++; $display("FAIL wrap_00_addr got=%h exp=00", bus.ram_addr); end
        repeat (2) step();
        checks++; if (MonDReg !== 32'h00C0FFEE) begin errors++; $display("FAIL wrap_00_data got=%h exp=00c0ffee", MonDReg); end
    endtask

    task automatic test_overrun();
        jdo = jdata(32'h11111111); take_b = 1'b1;
        step();
        jdo = jdata(32'h22222222);
        step();
        take_b = 1'b0;
        checks++; if (monitor_error !== 1'b1) begin errors++; $display("FAIL ovr_b_error got=%b exp=1", monitor_error); end
        checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 8'h01 || bus.ram_wdata !== 32'h11111111) begin errors++; $display("FAIL ovr_b_access got we=%b addr=%h wdata=%h exp 1/01/11111111", bus.ram_we, bus.ram_addr, bus.ram_wdata); end
        repeat (3) step();
        checks++; if (mem[8'h01] !== 32'h11111111 || mem[8'h02] !== 32'h0) begin errors++; $display("FAIL ovr_b_mem got m1=%h m2=%h exp 11111111/0", mem[8'h01], mem[8'h02]); end
        checks++; if (monitor_error !== 1'b1 || monitor_ready !== 1'b1) begin errors++; $display("FAIL ovr_b_status got err=%b rdy=%b exp 1/1", monitor_error, monitor_ready); end

        jdo = jaddr(8'h50); take_a = 1'b1;
        step();
        checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL ovr_a_clear got=%b exp=0", monitor_error); end
        jdo = jaddr(8'h60);
        step();
        take_a = 1'b0;
        checks++; if (monitor_error !== 1'b1 || bus.ram_addr !== 8'h50) begin errors++; $display("FAIL ovr_a_self got err=%b addr=%h exp 1/50", monitor_error, bus.ram_addr); end
        repeat (3) step();
        jtag_strobe(K_A, jaddr(8'h20));
        checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL ovr_a_later got=%b exp=0", monitor_error); end
        repeat (3) step();
        checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL ovr_a_done got=%b exp=1", monitor_ready); end
    endtask

    task automatic test_cpu();
        bus.cpu_req = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 8'h42; bus.cpu_wdata = 32'h0;
        step();
        checks++; if (bus.cpu_ack !== 1'b0 || bus.ram_addr !== 8'h42 || bus.ram_we !== 1'b0) begin errors++; $display("FAIL cpurd_c1 got ack=%b addr=%h we=%b exp 0/42/0", bus.cpu_ack, bus.ram_addr, bus.ram_we); end
        step();
        checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 32'h12345678) begin errors++; $display("FAIL cpurd_c2 got ack=%b rdata=%h exp 1/12345678", bus.cpu_ack, bus.cpu_rdata); end
        bus.cpu_req = 1'b0;
        step();
        checks++; if (bus.cpu_ack !== 1'b0 || bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL cpurd_c3 got ack=%b rdata=%h exp 0/0", bus.cpu_ack, bus.cpu_rdata); end

        bus.cpu_req = 1'b1; bus.cpu_write = 1'b1; bus.cpu_addr = 8'h43; bus.cpu_wdata = 32'h0F0F0F0F;
        step();
        checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 8'h43 || bus.ram_wdata !== 32'h0F0F0F0F) begin errors++; $display("FAIL cpuwr_c1 got we=%b addr=%h wdata=%h exp 1/43/0f0f0f0f", bus.ram_we, bus.ram_addr, bus.ram_wdata); end
        step();
        checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL cpuwr_c2 got ack=%b rdata=%h exp 1/0", bus.cpu_ack, bus.cpu_rdata); end
        bus.cpu_req = 1'b0; bus.cpu_write = 1'b0;
        step();
        checks++; if (mem[8'h43] !== 32'h0F0F0F0F) begin errors++; $display("FAIL cpuwr_mem got=%h exp=0f0f0f0f", mem[8'h43]); end
    endtask

    task automatic test_back_to_back();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        jtag_strobe(K_A, jaddr(8'h42));
        bus.cpu_req = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 8'h43;
        step();
        checks++; if (bus.ram_addr !== 8'h42 || bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL tie1_jtag_first got addr=%h ack=%b exp 42/0", bus.ram_addr, bus.cpu_ack); end
        step();
        step();
        checks++; if (monitor_ready !== 1'b1 || MonDReg !== 32'h12345678 || bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL tie1_jtag_done got rdy=%b data=%h ack=%b exp 1/12345678/0", monitor_ready, MonDReg, bus.cpu_ack); end
        step();
        checks++; if (bus.ram_addr !== 8'h43) begin errors++; $display("FAIL tie1_cpu_access got addr=%h exp 43", bus.ram_addr); end
        step();
        checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 32'h0F0F0F0F) begin errors++; $display("FAIL tie1_cpu_ack got ack=%b rdata=%h exp 1/0f0f0f0f", bus.cpu_ack, bus.cpu_rdata); end
        bus.cpu_req = 1'b0;
        step();

        jtag_strobe(K_NA, 38'h0);
        repeat (3) step();
        checks++; if (MonDReg !== 32'h0F0F0F0F) begin errors++; $display("FAIL solo_jtag got=%h exp=0f0f0f0f", MonDReg); end

        jtag_strobe(K_NA, 38'h0);
        bus.cpu_req = 1'b1; bus.cpu_addr = 8'h11;
        step();
        checks++; if (bus.ram_addr !== 8'h11) begin errors++; $display("FAIL tie2_cpu_first got addr=%h exp 11", bus.ram_addr); end
        step();
        checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL tie2_cpu_ack got ack=%b rdata=%h exp 1/deadbeef", bus.cpu_ack, bus.cpu_rdata); end
        step();
        checks++; if (bus.cpu_ack !== 1'b0 || monitor_ready !== 1'b0) begin errors++; $display("FAIL b2b_gap got ack=%b rdy=%b exp 0/0", bus.cpu_ack, monitor_ready); end
        step();
        checks++; if (bus.ram_addr !== 8'h44) begin errors++; $display("FAIL b2b_jtag_access got addr=%h exp 44", bus.ram_addr); end
        step();
        checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL b2b_jtag_complete got ack=%b exp 0", bus.cpu_ack); end
        step();
        checks++; if (monitor_ready !== 1'b1 || MonDReg !== 32'h0) begin errors++; $display("FAIL b2b_jtag_done got rdy=%b data=%h exp 1/0", monitor_ready, MonDReg); end
        step();
        checks++; if (bus.ram_addr !== 8'h11 || bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL b2b_cpu_access got addr=%h ack=%b exp 11/0", bus.ram_addr, bus.cpu_ack); end
        step();
        checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_cpu_ack got ack=%b rdata=%h exp 1/deadbeef", bus.cpu_ack, bus.cpu_rdata); end
        bus.cpu_req = 1'b0;
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset_n = 1'b0;
        jdo = 38'h0;
        take_a = 1'b0; take_na = 1'b0; take_b = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_write = 1'b0; bus.cpu_addr = 8'h0; bus.cpu_wdata = 32'h0;
        step();
        test_reset();
        test_jtag_write_read();
        test_wrap();
        test_overrun();
        test_cpu();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
